// File: rtl/alu_ctrl_gen.sv
// RV32I ALU-control encoder: combinational decode of the incoming word, one
// registered output stage backed by a one-entry skid register.
module alu_ctrl_gen #(
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_alu_ctr,
    output logic             out_illegal,
    output logic [31:0]      out_inst,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Bit 0 marks OR full, bit 1 marks SR full, so the handshake outputs
    // come straight off state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    typedef struct packed {
        logic [3:0]       ctr;
        logic             illegal;
        logic [31:0]      inst;
        logic [TAG_W-1:0] tag;
    } word_t;

    state_e state_q, state_d;
    word_t  or_q, or_d;
    word_t  sr_q, sr_d;
    word_t  new_w;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] dec_ctr;
    logic       dec_ill;
    logic       accept;
    logic       drain;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    // Illegal paths only raise dec_ill; dec_ctr keeps its zero default.
    always_comb begin
        dec_ctr = '0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec_ctr = {1'b0, funct3};
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_ctr = {1'b1, funct3};
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b001: begin
                        if (funct7 == F7_BASE) dec_ctr = 4'b0001;
                        else                   dec_ill = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     dec_ctr = 4'b0101;
                        else if (funct7 == F7_ALT) dec_ctr = 4'b1101;
                        else                       dec_ill = 1'b1;
                    end
                    default: dec_ctr = {1'b0, funct3};
                endcase
            end
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   dec_ctr = 4'b1000;
                    2'b10:   dec_ctr = 4'b0010;
                    2'b11:   dec_ctr = 4'b0011;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: begin
                dec_ctr = 4'b0000;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        new_w         = '0;
        new_w.ctr     = dec_ctr;
        new_w.illegal = dec_ill;
        new_w.inst    = in_inst;
        new_w.tag     = in_tag;
    end

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sr_d    = sr_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    or_d    = new_w;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    or_d = new_w;
                end else if (accept) begin
                    sr_d    = new_w;
                    state_d = TWO;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    or_d    = sr_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            or_q    <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            or_q    <= or_d;
            sr_q    <= sr_d;
        end
    end

    assign out_alu_ctr = or_q.ctr;
    assign out_illegal = or_q.illegal;
    assign out_inst    = or_q.inst;
    assign out_tag     = or_q.tag;

endmodule

// File: tb/tb_alu_ctrl_gen.sv
// Directed bench for alu_ctrl_gen: decode table, latency, backpressure,
// streaming throughput and mid-stream reset.
module tb_alu_ctrl_gen;

    localparam int unsigned TAG_W = 32;
    localparam int NV = 34;
    localparam int NS = 100;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  ctr;
        logic        ill;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_inst = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [3:0]       out_alu_ctr;
    logic             out_illegal;
    logic [31:0]      out_inst;
    logic [TAG_W-1:0] out_tag;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [NV];
    int   sidx [NS];

    always #5 clk = ~clk;

    alu_ctrl_gen #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu_ctr(out_alu_ctr),
        .out_illegal(out_illegal),
        .out_inst   (out_inst),
        .out_tag    (out_tag)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] obs_word();
        return {26'b0, out_valid, out_illegal, out_alu_ctr, out_inst, out_tag};
    endfunction

    function automatic logic [95:0] exp_word(input logic ill, input logic [3:0] ctr,
                                             input logic [31:0] inst, input logic [31:0] tag);
        return {26'b0, 1'b1, ill, ctr, inst, tag};
    endfunction

    task automatic send_one(input int i);
        @(negedge clk);
        in_valid = 1'b1;
        in_inst  = vecs[i].inst;
        in_tag   = 32'hA000_0000 + 32'(i);
        check("dir_ready", 96'(in_ready), 96'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check($sformatf("dir_out[%0d]", i), obs_word(),
              exp_word(vecs[i].ill, vecs[i].ctr, vecs[i].inst, 32'hA000_0000 + 32'(i)));
        @(negedge clk);
        check("dir_drained", 96'(out_valid), 96'(0));
    endtask

    initial begin
        vecs[0]  = '{32'h003100B3, 4'h0, 1'b0}; // add
        vecs[1]  = '{32'h403100B3, 4'h8, 1'b0}; // sub
        vecs[2]  = '{32'h003110B3, 4'h1, 1'b0}; // sll
        vecs[3]  = '{32'h003120B3, 4'h2, 1'b0}; // slt
        vecs[4]  = '{32'h003130B3, 4'h3, 1'b0}; // sltu
        vecs[5]  = '{32'h003140B3, 4'h4, 1'b0}; // xor
        vecs[6]  = '{32'h003150B3, 4'h5, 1'b0}; // srl
        vecs[7]  = '{32'h403150B3, 4'hD, 1'b0}; // sra
        vecs[8]  = '{32'h003160B3, 4'h6, 1'b0}; // or
        vecs[9]  = '{32'h003170B3, 4'h7, 1'b0}; // and
        vecs[10] = '{32'h023100B3, 4'h0, 1'b1}; // mul
        vecs[11] = '{32'h403140B3, 4'h0, 1'b1}; // alt funct7 with xor
        vecs[12] = '{32'h40315093, 4'hD, 1'b0}; // srai
        vecs[13] = '{32'h00315093, 4'h5, 1'b0}; // srli
        vecs[14] = '{32'h00311093, 4'h1, 1'b0}; // slli
        vecs[15] = '{32'h40311093, 4'h0, 1'b1}; // slli bad funct7
        vecs[16] = '{32'h02315093, 4'h0, 1'b1}; // srli bad funct7
        vecs[17] = '{32'h0FF17093, 4'h7, 1'b0}; // andi
        vecs[18] = '{32'h40010093, 4'h0, 1'b0}; // addi, imm bit30 set
        vecs[19] = '{32'h00316463, 4'h3, 1'b0}; // bltu
        vecs[20] = '{32'h00310463, 4'h8, 1'b0}; // beq
        vecs[21] = '{32'h00314463, 4'h2, 1'b0}; // blt
        vecs[22] = '{32'h00312463, 4'h0, 1'b1}; // branch funct3 010
        vecs[23] = '{32'h00317463, 4'h3, 1'b0}; // bgeu
        vecs[24] = '{32'h00012083, 4'h0, 1'b0}; // lw
        vecs[25] = '{32'h00112023, 4'h0, 1'b0}; // sw
        vecs[26] = '{32'h0000006F, 4'h0, 1'b0}; // jal
        vecs[27] = '{32'h00008067, 4'h0, 1'b0}; // jalr
        vecs[28] = '{32'h123450B7, 4'h0, 1'b0}; // lui
        vecs[29] = '{32'h00000097, 4'h0, 1'b0}; // auipc
        vecs[30] = '{32'h0000007F, 4'h0, 1'b1}; // opcode 0x7F
        vecs[31] = '{32'h0000000B, 4'h0, 1'b1}; // custom-0
        vecs[32] = '{32'h00312093, 4'h2, 1'b0}; // slti
        vecs[33] = '{32'h00314093, 4'h4, 1'b0}; // xori

        // Reset state
        @(negedge clk);
        check("rst_out", obs_word(), 96'(0));
        check("rst_ready", 96'(in_ready), 96'(1));
        rst = 1'b0;

        // Directed decode with latency check
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send_one(i);

        // Backpressure: A, B accepted, C held until drain starts
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = vecs[1].inst;
        in_tag    = 32'hB1;
        check("bp_ready0", 96'(in_ready), 96'(1));
        @(negedge clk);
        check("bp_A_out", obs_word(), exp_word(1'b0, 4'h8, vecs[1].inst, 32'hB1));
        check("bp_ready1", 96'(in_ready), 96'(1));
        in_inst = vecs[7].inst;
        in_tag  = 32'hB2;
        @(negedge clk);
        check("bp_full_ready", 96'(in_ready), 96'(0));
        check("bp_A_hold1", obs_word(), exp_word(1'b0, 4'h8, vecs[1].inst, 32'hB1));
        in_inst = vecs[10].inst;
        in_tag  = 32'hB3;
        @(negedge clk);
        check("bp_full_ready2", 96'(in_ready), 96'(0));
        check("bp_A_hold2", obs_word(), exp_word(1'b0, 4'h8, vecs[1].inst, 32'hB1));
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_B_out", obs_word(), exp_word(1'b0, 4'hD, vecs[7].inst, 32'hB2));
        check("bp_ready_back", 96'(in_ready), 96'(1));
        @(negedge clk);
        check("bp_C_out", obs_word(), exp_word(1'b1, 4'h0, vecs[10].inst, 32'hB3));
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_empty", 96'(out_valid), 96'(0));

        // Streaming at one word per cycle
        for (int k = 0; k < NS; k++) sidx[k] = int'($urandom_range(NV - 1, 0));
        for (int k = 0; k <= NS; k++) begin
            if (k > 0)
                check($sformatf("stream[%0d]", k - 1), obs_word(),
                      exp_word(vecs[sidx[k-1]].ill, vecs[sidx[k-1]].ctr,
                               vecs[sidx[k-1]].inst, 32'h1000 + 32'(k - 1)));
            check("stream_ready", 96'(in_ready), 96'(1));
            if (k < NS) begin
                in_valid = 1'b1;
                in_inst  = vecs[sidx[k]].inst;
                in_tag   = 32'h1000 + 32'(k);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("stream_empty", 96'(out_valid), 96'(0));

        // Mid-stream asynchronous reset
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = vecs[0].inst;
        in_tag    = 32'hC1;
        @(negedge clk);
        in_inst = vecs[1].inst;
        in_tag  = 32'hC2;
        @(negedge clk);
        in_valid = 1'b0;
        check("rm_full", 96'(in_ready), 96'(0));
        #2 rst = 1'b1;
        #1;
        check("rm_async_out", obs_word(), 96'(0));
        check("rm_async_ready", 96'(in_ready), 96'(1));
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = vecs[12].inst;
        in_tag    = 32'hD1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rm_first", obs_word(), exp_word(1'b0, 4'hD, vecs[12].inst, 32'hD1));
        @(negedge clk);
        check("rm_no_stale1", 96'(out_valid), 96'(0));
        @(negedge clk);
        check("rm_no_stale2", 96'(out_valid), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
